// File: rtl/unidade_controle_jogo.sv
// rtl/unidade_controle_jogo.sv - match controller FSM for the game datapath
module unidade_controle_jogo #(
    parameter int unsigned MAX_MORTES = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       confirmar,
    input  logic       CJ_fim,
    input  logic       jogador_vivo,
    input  logic [1:0] classe_atual,
    input  logic [4:0] mortes,
    output logic       rst_global,
    output logic       zera_CS,
    output logic       inc_seed,
    output logic       e_seed_reg,
    output logic       zera_CJ,
    output logic       inc_jogador,
    output logic       mostra_classe,
    output logic       processar_acao,
    output logic       avaliar_eliminacao,
    output logic       pronto,
    output logic       fim_jogo,
    output logic [3:0] db_estado,
    output logic [3:0] db_noite
);

    typedef enum logic [3:0] {
        INICIAL   = 4'h0,
        SORTEIO   = 4'h1,
        CARREGA   = 4'h2,
        GRAVA     = 4'h3,
        ESPERA_R  = 4'h4,
        REVELA    = 4'h5,
        ESPERA_N  = 4'h6,
        AVALIA_N  = 4'h7,
        ACAO      = 4'h8,
        PROXIMO   = 4'h9,
        ELIMINA   = 4'hA,
        RESULTADO = 4'hB,
        EXECUTA   = 4'hC,
        PROX_R    = 4'hD,
        INICIA_N  = 4'hE,
        FIM       = 4'hF
    } estado_t;

    estado_t    estado;
    estado_t    prox;
    logic       confirmar_q;
    logic       conf_ev;
    logic       inc_revela;
    logic [2:0] n_mortes;
    logic       fim_cond;

    assign conf_ev   = confirmar & ~confirmar_q;
    assign n_mortes  = {2'b00, mortes[0]} + {2'b00, mortes[1]} + {2'b00, mortes[2]}
                     + {2'b00, mortes[3]} + {2'b00, mortes[4]};
    assign fim_cond  = 32'(n_mortes) >= MAX_MORTES;
    assign db_estado = estado;
    // Only Mealy path: advance the player straight out of PROXIMO unless it was the last one.
    assign inc_jogador = inc_revela | ((estado == PROXIMO) & ~CJ_fim);

    always_comb begin
        prox = estado;
        case (estado)
            INICIAL:   prox = SORTEIO;
            SORTEIO:   if (iniciar) prox = CARREGA;
            CARREGA:   prox = GRAVA;
            GRAVA:     prox = ESPERA_R;
            ESPERA_R:  prox = REVELA;
            REVELA:    if (conf_ev) prox = CJ_fim ? INICIA_N : PROX_R;
            PROX_R:    prox = ESPERA_R;
            INICIA_N:  prox = ESPERA_N;
            ESPERA_N:  prox = AVALIA_N;
            AVALIA_N:  prox = (!jogador_vivo || classe_atual == 2'b00 || classe_atual == 2'b11)
                              ? PROXIMO : ACAO;
            ACAO:      if (conf_ev) prox = EXECUTA;
            EXECUTA:   prox = PROXIMO;
            PROXIMO:   prox = CJ_fim ? ELIMINA : ESPERA_N;
            ELIMINA:   prox = RESULTADO;
            RESULTADO: if (conf_ev) prox = fim_cond ? FIM : INICIA_N;
            FIM:       if (conf_ev) prox = INICIAL;
            default:   prox = INICIAL;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they decode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado             <= INICIAL;
            confirmar_q        <= 1'b0;
            db_noite           <= 4'd0;
            rst_global         <= 1'b1;
            zera_CS            <= 1'b1;
            zera_CJ            <= 1'b1;
            inc_seed           <= 1'b0;
            e_seed_reg         <= 1'b0;
            inc_revela         <= 1'b0;
            mostra_classe      <= 1'b0;
            processar_acao     <= 1'b0;
            avaliar_eliminacao <= 1'b0;
            pronto             <= 1'b0;
            fim_jogo           <= 1'b0;
        end else begin
            estado      <= prox;
            confirmar_q <= confirmar;
            if (prox == INICIAL)
                db_noite <= 4'd0;
            else if (estado == ELIMINA && db_noite != 4'hF)
                db_noite <= db_noite + 4'd1;
            rst_global         <= (prox == INICIAL);
            zera_CS            <= (prox == INICIAL);
            zera_CJ            <= (prox inside {INICIAL, GRAVA, INICIA_N});
            inc_seed           <= (prox == SORTEIO);
            e_seed_reg         <= (prox == GRAVA);
            inc_revela         <= (prox == PROX_R);
            mostra_classe      <= (prox inside {REVELA, ESPERA_N, AVALIA_N, ACAO, EXECUTA});
            processar_acao     <= (prox == EXECUTA);
            avaliar_eliminacao <= (prox == ELIMINA);
            pronto             <= (prox inside {REVELA, ACAO, RESULTADO, FIM});
            fim_jogo           <= (prox == FIM);
        end
    end

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// tb/tb_unidade_controle_jogo.sv - scoreboard bench for unidade_controle_jogo
module tb_unidade_controle_jogo;

    logic       clock = 1'b0;
    logic       reset, iniciar, confirmar, CJ_fim, jogador_vivo;
    logic [1:0] classe_atual;
    logic [4:0] mortes;
    logic       rst_global, zera_CS, inc_seed, e_seed_reg, zera_CJ, inc_jogador;
    logic       mostra_classe, processar_acao, avaliar_eliminacao, pronto, fim_jogo;
    logic [3:0] db_estado, db_noite;

    unidade_controle_jogo #(.MAX_MORTES(3)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .confirmar(confirmar),
        .CJ_fim(CJ_fim), .jogador_vivo(jogador_vivo), .classe_atual(classe_atual),
        .mortes(mortes), .rst_global(rst_global), .zera_CS(zera_CS), .inc_seed(inc_seed),
        .e_seed_reg(e_seed_reg), .zera_CJ(zera_CJ), .inc_jogador(inc_jogador),
        .mostra_classe(mostra_classe), .processar_acao(processar_acao),
        .avaliar_eliminacao(avaliar_eliminacao), .pronto(pronto), .fim_jogo(fim_jogo),
        .db_estado(db_estado), .db_noite(db_noite)
    );

    always #5 clock = ~clock;

    // Datapath stand-in: player counter, class table and death vector.
    logic [2:0] cnt;
    logic [1:0] cls [8];
    logic [4:0] kill_plan;
    logic [7:0] mortes_ext;

    always @(posedge clock) begin
        if (zera_CJ) cnt <= 3'd0;
        else if (inc_jogador) cnt <= cnt + 3'd1;
        if (rst_global) mortes <= 5'd0;
        else if (avaliar_eliminacao) mortes <= mortes | kill_plan;
    end

    always_comb begin
        mortes_ext   = {3'b000, mortes};
        CJ_fim       = (cnt == 3'd4);
        classe_atual = mostra_classe ? cls[cnt] : 2'b11;
        jogador_vivo = ~mortes_ext[cnt];
    end

    typedef struct packed {
        logic [3:0] kind;
        logic [7:0] a;
        logic [7:0] b;
    } ev_t;

    localparam int EV_SEED = 1, EV_INC = 2, EV_WAIT = 3, EV_ACT = 4,
                   EV_ELIM = 5, EV_RES = 6, EV_FIM = 7;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    logic [4:0] dead;
    int  nights;

    function automatic ev_t mk(input int k, input int a, input int b);
        ev_t e;
        e.kind = k[3:0];
        e.a    = a[7:0];
        e.b    = b[7:0];
        return e;
    endfunction

    task automatic push(input int k, input int a, input int b);
        exp_q.push_back(mk(k, a, b));
    endtask

    task automatic observe(input ev_t got);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL event_unexpected: got kind=%0d a=%0d b=%0d, none expected",
                     got.kind, got.a, got.b);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_bad++;
                $display("FAIL event_order: got kind=%0d a=%0d b=%0d, expected kind=%0d a=%0d b=%0d",
                         got.kind, got.a, got.b, e.kind, e.a, e.b);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Monitor: turns observable DUT activity into events and checks them in order.
    int         cyc = 0, last_seed = 0, seed_cnt = 0;
    logic [3:0] prev_st = 4'd0;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            prev_st  = 4'd0;
            seed_cnt = 0;
        end else begin
            if (db_estado == 4'd0) seed_cnt = 0;
            if (inc_seed) begin
                seed_cnt++;
                last_seed = cyc;
            end
            if (e_seed_reg) observe(mk(EV_SEED, seed_cnt, cyc - last_seed));
            if (inc_jogador) observe(mk(EV_INC, int'(cnt), 0));
            if (db_estado == 4'd8 && prev_st != 4'd8) observe(mk(EV_WAIT, int'(cnt), 0));
            if (processar_acao) observe(mk(EV_ACT, int'(cnt), 0));
            if (avaliar_eliminacao) observe(mk(EV_ELIM, int'(db_noite), 0));
            if (db_estado == 4'd11 && prev_st != 4'd11) observe(mk(EV_RES, int'(db_noite), 0));
            if (fim_jogo && prev_st != 4'd15) observe(mk(EV_FIM, int'(db_noite), 0));
            prev_st = db_estado;
        end
    end

    task automatic wait_state(input logic [3:0] s);
        bit ok;
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clock);
            if (db_estado == s) ok = 1;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_state: state %0d never reached, stuck at %0d", s, db_estado);
        end
    endtask

    task automatic press(input int hold);
        bit ok;
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clock);
            if (pronto) ok = 1;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL press_timeout: pronto never rose, state %0d", db_estado);
        end else begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            confirmar = 1'b1;
            repeat (hold) @(negedge clock);
            confirmar = 1'b0;
        end
    endtask

    task automatic start_game(input int k);
        dead   = 5'd0;
        nights = 0;
        push(EV_SEED, k, 2);
        for (int p = 0; p < 4; p++) push(EV_INC, p, 0);
        wait_state(4'd1);
        repeat (k - 1) @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    // One night from the rules: live attackers/protectors wait and act, everyone else is skipped.
    task automatic run_night(input logic [4:0] kill, input bit reveal, input bit hold_first,
                             input bit abort_acao, output bit over);
        int         n_act;
        logic [4:0] nd;
        n_act = 0;
        over  = 0;
        nd    = dead | kill;
        if (abort_acao) begin
            push(EV_WAIT, 0, 0);
        end else begin
            for (int p = 0; p < 5; p++) begin
                if (!dead[p] && (cls[p] == 2'b01 || cls[p] == 2'b10)) begin
                    push(EV_WAIT, p, 0);
                    push(EV_ACT, p, 0);
                    n_act++;
                end
                if (p < 4) push(EV_INC, p, 0);
            end
            push(EV_ELIM, nights, 0);
            push(EV_RES, (nights + 1 > 15) ? 15 : nights + 1, 0);
            over = ($countones(nd) >= 3);
            if (over) push(EV_FIM, nights + 1, 0);
        end
        kill_plan = kill;
        if (reveal) begin
            for (int i = 0; i < 5; i++) begin
                press((hold_first && i == 0) ? 20 : 1);
                if (hold_first && i == 0) chk("hold_counts_once", 32'(db_estado), 5);
            end
            if (hold_first) begin
                @(negedge clock);
                chk("reveal_ends_espera_n", 32'(db_estado), 6);
                chk("reveal_zera_cj", 32'(cnt), 0);
            end
        end
        if (abort_acao) begin
            wait_state(4'd8);
            #1;
            chk("queue_drained_before_reset", 32'(exp_q.size()), 0);
            return;
        end
        repeat (n_act) press(1);
        press(1);
        dead = nd;
        nights++;
        if (over) begin
            press(1);
            chk("fim_to_inicial", 32'(db_estado), 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         over;
        logic [4:0] kill;
        reset     = 1'b1;
        iniciar   = 1'b0;
        confirmar = 1'b0;
        kill_plan = 5'd0;
        for (int i = 0; i < 8; i++) cls[i] = 2'b00;
        repeat (2) @(negedge clock);
        chk("reset_estado", 32'(db_estado), 0);
        chk("reset_rst_global", 32'(rst_global), 1);
        chk("reset_zera_cs", 32'(zera_CS), 1);
        chk("reset_zera_cj", 32'(zera_CJ), 1);
        chk("reset_pronto", 32'(pronto), 0);
        chk("reset_inc_seed", 32'(inc_seed), 0);
        chk("reset_noite", 32'(db_noite), 0);
        reset = 1'b0;
        #1;
        chk("release_estado", 32'(db_estado), 0);
        chk("release_rst_global", 32'(rst_global), 1);

        // Game 1: attacker at 1, protector at 3; attacker dies in night 1 and is skipped in night 2.
        cls[1] = 2'b01;
        cls[3] = 2'b10;
        start_game(7);
        run_night(5'b00011, 1'b1, 1'b1, 1'b0, over);
        run_night(5'b00100, 1'b0, 1'b0, 1'b0, over);
        chk("game1_over", 32'(over), 1);

        // Game 2: asynchronous reset while waiting in ACAO of night 2.
        for (int i = 0; i < 5; i++) cls[i] = 2'($urandom_range(0, 3));
        cls[0] = 2'b01;
        start_game($urandom_range(1, 10));
        run_night(5'b00000, 1'b1, 1'b0, 1'b0, over);
        run_night(5'b00000, 1'b0, 1'b0, 1'b1, over);
        reset = 1'b1;
        #1;
        chk("async_reset_estado", 32'(db_estado), 0);
        chk("async_reset_rst_global", 32'(rst_global), 1);
        chk("async_reset_noite", 32'(db_noite), 0);
        chk("async_reset_pronto", 32'(pronto), 0);
        chk("async_reset_mostra", 32'(mostra_classe), 0);
        exp_q.delete();
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Random games: random classes and random kills until the match ends.
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 5; i++) cls[i] = 2'($urandom_range(0, 3));
            start_game($urandom_range(1, 10));
            over = 0;
            for (int n = 0; n < 6 && !over; n++) begin
                kill = 5'($urandom_range(0, 31)) & ~dead;
                if (kill == 5'd0) begin
                    for (int p = 4; p >= 0; p--) if (!dead[p]) kill = 5'(1 << p);
                end
                run_night(kill, n == 0, 1'b0, 1'b0, over);
            end
            chk("random_game_over", 32'(over), 1);
        end

        @(negedge clock);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/unidade_controle_jogo.md
# unidade_controle_jogo

Moore FSM controller for the game datapath (`fluxo_dados`). It runs the whole match:
- spins the seed counter until start;
- latches the seed;
- walks the five players through a private class reveal;
- runs night rounds: each live attacker (class `01`) or protector (class `10`) picks a target, then the elimination is applied;
- ends the match when enough players have died.

It drives every control input of `fluxo_dados` and sits between it and the button/display layer.

## Interface
Parameters:
- `MAX_MORTES`, default 3: the match ends once this many players are dead.

Ports:
- `clock`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high; forces state `INICIAL`
- `iniciar`  in  1  level; ends seed spinning
- `confirmar`  in  1  player confirm button; only 0→1 transitions count
- `CJ_fim`  in  1  player counter at last player (player 4)
- `jogador_vivo`  in  1  current player alive
- `classe_atual`  in  2  gated class from the datapath (`11` while `mostra_classe`=0)
- `mortes`  in  5  death vector from the datapath
- `rst_global`, `zera_CS`, `inc_seed`, `e_seed_reg`, `zera_CJ`, `inc_jogador`, `mostra_classe`, `processar_acao`, `avaliar_eliminacao`  out  1 each  datapath controls
- `pronto`  out  1  FSM is waiting for a `confirmar` edge
- `fim_jogo`  out  1  match over
- `db_estado`  out  4  state code
- `db_noite`  out  4  completed nights, saturates at 15

## Operation
Edge detection on `confirmar`:
- `confirmar` is registered; the event is `conf_ev = confirmar & ~confirmar_q`.
- `confirmar_q` clears on reset.

All outputs are Moore, decoded from state. Each state below lists its code, the outputs it asserts, and its transitions.
- `INICIAL` (0): asserts `rst_global`, `zera_CS`, `zera_CJ`. Next state `SORTEIO`.
- `SORTEIO` (1): asserts `inc_seed`. Goes to `CARREGA` when `iniciar`=1.
- `CARREGA` (2): no outputs. Covers the seed ROM read latency. Next `GRAVA`.
- `GRAVA` (3): asserts `e_seed_reg`, `zera_CJ`. Next `ESPERA_R`.
- `ESPERA_R` (4): no outputs. Covers the class parser latency. Next `REVELA`.
- `REVELA` (5): asserts `mostra_classe`, `pronto`.
  - On `conf_ev`: go to `INICIA_N` if `CJ_fim`, else `PROX_R`.
- `PROX_R` (D): asserts `inc_jogador`. Next `ESPERA_R`.
- `INICIA_N` (E): asserts `zera_CJ`. Next `ESPERA_N`.
- `ESPERA_N` (6): asserts `mostra_classe`. Next `AVALIA_N`.
- `AVALIA_N` (7): asserts `mostra_classe`.
  - If `jogador_vivo`=0, or `classe_atual` is `00` or `11`: go to `PROXIMO`.
  - Otherwise go to `ACAO`.
- `ACAO` (8): asserts `mostra_classe`, `pronto`. On `conf_ev` go to `EXECUTA`.
- `EXECUTA` (C): asserts `mostra_classe`, `processar_acao` (exactly one cycle). Next `PROXIMO`.
- `PROXIMO` (9): no outputs.
  - If `CJ_fim`: go to `ELIMINA`.
  - Otherwise assert `inc_jogador` and go to `ESPERA_N`. This is the single Mealy exception, gated by state and `CJ_fim` only.
- `ELIMINA` (A): asserts `avaliar_eliminacao` (one cycle). Increments `db_noite`, saturating. Next `RESULTADO`.
- `RESULTADO` (B): asserts `pronto`.
  - On `conf_ev`: go to `FIM` if popcount(`mortes`) ≥ `MAX_MORTES`, else `INICIA_N`.
- `FIM` (F): asserts `fim_jogo`, `pronto`. On `conf_ev` go to `INICIAL`.
- Unused codes go to `INICIAL`.

Other rules:
- `db_noite` clears in `INICIAL`.
- Popcount is a 3-bit sum of the 5 death bits, compared unsigned.

## Timing
- Reset values: state `INICIAL`, `db_noite`=0, `confirmar_q`=0.
- During reset and the first cycle after release: `rst_global`=`zera_CS`=`zera_CJ`=1, all other outputs 0.
- Reset mid-operation aborts immediately. It does not wait for the end of a round.
- Seed latency: `iniciar` sampled at edge n. `inc_seed` drops after edge n. `e_seed_reg` is high in cycle n+2.
- Class/alive samples are only taken at least one cycle after any `zera_CJ` or `inc_jogador`.
- `AVALIA_N` must run with `mostra_classe` already high for one cycle.
- `mortes` is sampled in `RESULTADO`, at least one cycle after `avaliar_eliminacao`.
- `confirmar` held high produces one event. Its release is ignored.
- `conf_ev` outside the `pronto` states is discarded, not queued.
- `iniciar` outside `SORTEIO` is ignored.

## Test plan
- Reset: assert `reset` in `ACAO` → `db_estado`=0 asynchronously; `rst_global`=1; `db_noite`=0.
- Seed: hold `iniciar`=0 for 7 cycles then 1 → exactly 7 `inc_seed` cycles (8 if `iniciar` rises on the 8th); `e_seed_reg` pulses once, 2 cycles after `iniciar` is sampled.
- Reveal: 5 `conf_ev` pulses → 4 `inc_jogador` pulses, then `zera_CJ`, then state `ESPERA_N`.
  - Holding `confirmar` 20 cycles counts once.
- Night, player 1 = class `01` and player 3 = class `10`, others `00`, all alive:
  - exactly 2 `ACAO` waits;
  - 2 one-cycle `processar_acao` pulses;
  - 1 `avaliar_eliminacao` pulse;
  - `db_noite`=1.
- Dead skip: `jogador_vivo`=0 for the attacker → no `ACAO` for that player, no `processar_acao` from it.
- End: `mortes`=5'b00111 at `RESULTADO` plus `conf_ev` → `fim_jogo`=1.
  - `mortes`=5'b00011 → `INICIA_N` instead.
  - `conf_ev` in `FIM` → `INICIAL`.
